// File: rtl/clk_div_seq_ctrl_pkg.sv
// Shared types and helpers for the glitch-free clock divider update sequencer.
package clk_div_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GATE_OFF = 3'd1,
    ST_DIV_REQ  = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_GATE_ON  = 3'd4
  } state_e;

  // Counter only ever has to reach (max - 1) before it is cleared by a state change.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clk_div_seq_ctrl.sv
// Sequences a divider change: gate clock off, hand new value to the divider, settle, gate on.
// Optional DIV_REQ timeout is built only when CLK_DIV_SEQ_CTRL_TIMEOUT_EN is defined.
module clk_div_seq_ctrl
  import clk_div_seq_ctrl_pkg::*;
#(
  parameter int DIV_W       = 9,
  parameter int DEFAULT_DIV = 256,
  parameter int GATE_DLY    = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  input  logic [DIV_W-1:0] req_div_i,
  output logic             req_ready_o,
  output logic             div_valid_o,
  output logic [DIV_W-1:0] div_o,
  input  logic             div_ready_i,
  output logic             clk_en_o,
  output logic [DIV_W-1:0] cur_div_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int               CNT_W    = cnt_width(GATE_DLY, TIMEOUT);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(GATE_DLY - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
`endif

  // Handshakes: req is taken on req_valid_i & req_ready_o; the divider update is
  // taken on div_valid_o & div_ready_i, with div_o held stable until then.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cur_q, cur_d;
  logic             clk_en_q, clk_en_d;
  logic             done_q, done_d;
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          div_d = req_div_i;
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (req_div_i == cur_q) done_d  = 1'b1;
          else                    state_d = ST_GATE_OFF;
        end
      end
      ST_GATE_OFF: begin
        if (cnt_q == DLY_LAST) state_d = ST_DIV_REQ;
      end
      ST_DIV_REQ: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (div_ready_i) begin
          cur_d   = div_q;
          state_d = ST_SETTLE;
        end
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_SETTLE;
        end
`endif
      end
      ST_SETTLE: begin
        if (cnt_q == DLY_LAST) begin
          state_d = ST_GATE_ON;
          done_d  = 1'b1;
        end
      end
      ST_GATE_ON: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    cnt_d    = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + CNT_W'(1);
    // Registered from the next state so the gate enable never glitches.
    clk_en_d = (state_d == ST_IDLE) || (state_d == ST_GATE_ON);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      cur_q    <= DIV_RST;
      clk_en_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      cur_q    <= cur_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign div_valid_o = (state_q == ST_DIV_REQ);
  assign div_o       = div_q;
  assign clk_en_o    = clk_en_q;
  assign cur_div_o   = cur_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
`ifdef CLK_DIV_SEQ_CTRL_TIMEOUT_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule
